// File: rtl/jtag_tap_sync.sv
// JTAG TAP controller sampled in the system clock domain. TCK, TMS, TDI and
// TRSTn are synchronized and TCK edges are detected against a history flop.
// Registers: IR (5 bits), IDCODE (32 bits), BYPASS (1 bit) and a user DR
// whose update is handed to the system side through a valid/ready port.
module jtag_tap_sync #(
  parameter logic [31:0] IDCODE     = 32'h00000001,
  parameter logic [4:0]  USER_IR    = 5'h11,
  parameter int unsigned DATA_WIDTH = 41
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  jtag_TCK,
  input  logic                  jtag_TMS,
  input  logic                  jtag_TDI,
  input  logic                  jtag_TRSTn,
  output logic                  jtag_TDO_data,
  output logic                  jtag_TDO_driven,
  input  logic [DATA_WIDTH-1:0] dr_capture_data,
  output logic                  dr_update_valid,
  input  logic                  dr_update_ready,
  output logic [DATA_WIDTH-1:0] dr_update_data,
  output logic                  dr_overrun,
  output logic [4:0]            ir_value,
  output logic [3:0]            tap_state
);

  localparam logic [4:0] IR_IDCODE = 5'h01;

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  tap_state_e state, state_nxt;

  logic [3:0] sync_q1, sync_q2;
  logic       tck_hist;
  logic       tck_s, tms_s, tdi_s, trst_n_s;
  logic       tck_rise, tck_fall;

  logic [4:0]            ir_sr;
  logic [31:0]           id_sr;
  logic [DATA_WIDTH-1:0] user_sr;
  logic                  bypass_sr;

  logic sel_idcode, sel_user, dr_lsb;
  logic upd_user, xfer;

  assign {tck_s, tms_s, tdi_s, trst_n_s} = sync_q2;
  assign tck_rise = tck_s & ~tck_hist;
  assign tck_fall = ~tck_s & tck_hist;

  assign sel_idcode = (ir_value == IR_IDCODE);
  assign sel_user   = !sel_idcode && (ir_value == USER_IR);

  assign upd_user = tck_fall && trst_n_s && (state == UPD_DR) && (ir_value == USER_IR);
  assign xfer     = dr_update_valid && dr_update_ready;

  assign tap_state = state;

  // Two-flop synchronizers for the JTAG pins plus the TCK history flop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      tck_hist <= 1'b0;
    end else begin
      sync_q1  <= {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn};
      sync_q2  <= sync_q1;
      tck_hist <= tck_s;
    end
  end

  // TAP state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= TLR;
    else          state <= state_nxt;
  end

  // IEEE 1149.1 next-state logic; TRSTn overrides any TCK activity
  always_comb begin
    state_nxt = state;
    if (!trst_n_s) begin
      state_nxt = TLR;
    end else if (tck_rise) begin
      case (state)
        TLR:      state_nxt = tms_s ? TLR    : RTI;
        RTI:      state_nxt = tms_s ? SEL_DR : RTI;
        SEL_DR:   state_nxt = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
        SH_DR:    state_nxt = tms_s ? EX1_DR : SH_DR;
        EX1_DR:   state_nxt = tms_s ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_nxt = tms_s ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_nxt = tms_s ? UPD_DR : SH_DR;
        UPD_DR:   state_nxt = tms_s ? SEL_DR : RTI;
        SEL_IR:   state_nxt = tms_s ? TLR    : CAP_IR;
        CAP_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
        SH_IR:    state_nxt = tms_s ? EX1_IR : SH_IR;
        EX1_IR:   state_nxt = tms_s ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_nxt = tms_s ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_nxt = tms_s ? UPD_IR : SH_IR;
        UPD_IR:   state_nxt = tms_s ? SEL_DR : RTI;
        default:  state_nxt = TLR;
      endcase
    end
  end

  // Serial bit presented by the currently selected data register
  always_comb begin
    dr_lsb = bypass_sr;
    if (sel_idcode)    dr_lsb = id_sr[0];
    else if (sel_user) dr_lsb = user_sr[0];
  end

  // Capture and shift of IR and DRs on TCK rise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_sr     <= '0;
      id_sr     <= '0;
      user_sr   <= '0;
      bypass_sr <= 1'b0;
    end else if (tck_rise && trst_n_s) begin
      case (state)
        CAP_IR: ir_sr <= 5'b00001;
        SH_IR:  ir_sr <= {tdi_s, ir_sr[4:1]};
        CAP_DR: begin
          if (sel_idcode)    id_sr     <= {IDCODE[31:1], 1'b1};
          else if (sel_user) user_sr   <= dr_capture_data;
          else               bypass_sr <= 1'b0;
        end
        SH_DR: begin
          if (sel_idcode)    id_sr     <= {tdi_s, id_sr[31:1]};
          else if (sel_user) user_sr   <= {tdi_s, user_sr[DATA_WIDTH-1:1]};
          else               bypass_sr <= tdi_s;
        end
        default: ;
      endcase
    end
  end

  // TDO launch on TCK fall; data holds its last value while not driven
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
    end else if (!trst_n_s) begin
      jtag_TDO_driven <= 1'b0;
    end else if (tck_fall) begin
      if (state == SH_IR) begin
        jtag_TDO_data   <= ir_sr[0];
        jtag_TDO_driven <= 1'b1;
      end else if (state == SH_DR) begin
        jtag_TDO_data   <= dr_lsb;
        jtag_TDO_driven <= 1'b1;
      end else begin
        jtag_TDO_driven <= 1'b0;
      end
    end
  end

  // Instruction register and user DR handoff (valid/ready, sticky overrun)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_value        <= IR_IDCODE;
      dr_update_valid <= 1'b0;
      dr_update_data  <= '0;
      dr_overrun      <= 1'b0;
    end else begin
      if (state_nxt == TLR)                   ir_value <= IR_IDCODE;
      else if (tck_fall && state == UPD_IR)   ir_value <= ir_sr;

      // An update landing on the transfer cycle refills the slot instead of overrunning
      if (upd_user && (!dr_update_valid || xfer)) begin
        dr_update_data  <= user_sr;
        dr_update_valid <= 1'b1;
      end else if (xfer) begin
        dr_update_valid <= 1'b0;
      end

      if (state_nxt == TLR)                        dr_overrun <= 1'b0;
      else if (upd_user && dr_update_valid && !xfer) dr_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Self-checking bench for jtag_tap_sync: randomized JTAG sequences compared
// against a TCK-level behavioural model of the TAP and its registers.
module tb_jtag_tap_sync;

  localparam logic [31:0] IDC = 32'h00000001;
  localparam logic [4:0]  UIR = 5'h11;
  localparam int unsigned DW  = 41;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          jtag_TCK = 1'b0, jtag_TMS = 1'b1, jtag_TDI = 1'b0, jtag_TRSTn = 1'b1;
  logic          jtag_TDO_data, jtag_TDO_driven;
  logic [DW-1:0] dr_capture_data = '0;
  logic          dr_update_valid;
  logic          dr_update_ready = 1'b0;
  logic [DW-1:0] dr_update_data;
  logic          dr_overrun;
  logic [4:0]    ir_value;
  logic [3:0]    tap_state;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  jtag_tap_sync #(.IDCODE(IDC), .USER_IR(UIR), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .dr_capture_data(dr_capture_data), .dr_update_valid(dr_update_valid),
    .dr_update_ready(dr_update_ready), .dr_update_data(dr_update_data),
    .dr_overrun(dr_overrun), .ir_value(ir_value), .tap_state(tap_state)
  );

  // TAP transition table taken from the standard: index = state code
  int unsigned nx0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int unsigned nx1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  // Behavioural model state
  int unsigned   m_state, m_len;
  logic [4:0]    m_ir, m_ir_sr;
  logic [63:0]   m_dr;
  logic          m_tdo, m_drv, m_valid, m_ovr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_state = 15; m_len = 1; m_ir = 5'h01; m_ir_sr = '0; m_dr = '0;
    m_tdo = 1'b0; m_drv = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
  endtask

  task automatic model_rise(input logic tms, input logic tdi);
    case (m_state)
      6: begin
        if (m_ir == 5'h01)    begin m_dr = {32'h0, IDC | 32'h1}; m_len = 32; end
        else if (m_ir == UIR) begin m_dr = 64'(dr_capture_data); m_len = DW; end
        else                  begin m_dr = '0; m_len = 1; end
      end
      2:  m_dr = (m_dr >> 1) | (64'(tdi) << (m_len - 1));
      14: m_ir_sr = 5'b00001;
      10: m_ir_sr = (m_ir_sr >> 1) | (5'(tdi) << 4);
      default: ;
    endcase
    m_state = tms ? nx1[m_state] : nx0[m_state];
    if (m_state == 15) begin m_ir = 5'h01; m_ovr = 1'b0; end
  endtask

  task automatic model_fall(input logic xfer_now);
    if (m_state == 2 || m_state == 10) begin
      m_drv = 1'b1;
      m_tdo = (m_state == 10) ? m_ir_sr[0] : m_dr[0];
    end else begin
      m_drv = 1'b0;
    end
    if (m_state == 13) m_ir = m_ir_sr;
    if (m_state == 5 && m_ir == UIR) begin
      if (!m_valid || xfer_now) begin m_data = m_dr[DW-1:0]; m_valid = !dr_update_ready; end
      else m_ovr = 1'b1;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic jtag_rise(input logic tms, input logic tdi);
    jtag_TMS = tms; jtag_TDI = tdi;
    wait_clks(4);
    jtag_TCK = 1'b1; model_rise(tms, tdi);
    wait_clks(4);
  endtask

  task automatic jtag_fall();
    jtag_TCK = 1'b0; model_fall(dr_update_ready);
    wait_clks(4);
  endtask

  task automatic jtag_clk(input logic tms, input logic tdi);
    jtag_rise(tms, tdi);
    jtag_fall();
  endtask

  task automatic set_ready(input logic r);
    dr_update_ready = r;
    if (r) m_valid = 1'b0;
    wait_clks(2);
  endtask

  task automatic goto_rti();
    repeat (5) jtag_clk(1'b1, 1'b0);
    jtag_clk(1'b0, 1'b0);
  endtask

  // From RTI: load an instruction, return the captured IR bits, end in RTI
  task automatic load_ir(input logic [4:0] v, output logic [4:0] cap);
    jtag_clk(1'b1, 1'b0); jtag_clk(1'b1, 1'b0); jtag_clk(1'b0, 1'b0); jtag_clk(1'b0, 1'b0);
    cap = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      cap[i] = jtag_TDO_data;
      jtag_clk(i == 4, v[i]);
    end
    jtag_clk(1'b1, 1'b0); jtag_clk(1'b0, 1'b0);
  endtask

  // From RTI: shift len bits through the DR; optionally stop with TCK high in UpdDR
  task automatic shift_dr(input logic [63:0] din, input int unsigned len,
                          input bit stop_in_upd, output logic [63:0] dout);
    jtag_clk(1'b1, 1'b0); jtag_clk(1'b0, 1'b0); jtag_clk(1'b0, 1'b0);
    dout = '0;
    for (int unsigned i = 0; i < len; i++) begin
      dout[i] = jtag_TDO_data;
      jtag_clk(i == len - 1, din[i]);
    end
    if (stop_in_upd) begin
      jtag_rise(1'b1, 1'b0);
    end else begin
      jtag_clk(1'b1, 1'b0); jtag_clk(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    wait_clks(3);
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL reset_state got %h exp F", tap_state); end
    checks++; if (ir_value !== 5'h01) begin errors++; $display("FAIL reset_ir got %h exp 01", ir_value); end
    checks++; if (jtag_TDO_data !== 1'b0 || jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b%b exp 00", jtag_TDO_data, jtag_TDO_driven); end
    checks++; if (dr_update_valid !== 1'b0 || dr_overrun !== 1'b0 || dr_update_data !== '0) begin errors++; $display("FAIL reset_upd got v%b o%b d%h exp 0", dr_update_valid, dr_overrun, dr_update_data); end
    reset_n = 1'b1;
    wait_clks(4);
    jtag_clk(1'b1, 1'b0); jtag_clk(1'b1, 1'b1);
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL reset_hold_tlr got %h exp F", tap_state); end
  endtask

  task automatic test_idcode();
    logic [31:0] exp_id;
    exp_id = 32'h00000001;
    jtag_clk(1'b0, 1'b0); jtag_clk(1'b1, 1'b0); jtag_clk(1'b0, 1'b0); jtag_clk(1'b0, 1'b0);
    checks++; if (tap_state !== 4'h2) begin errors++; $display("FAIL idcode_shdr got %h exp 2", tap_state); end
    for (int unsigned i = 0; i < 32; i++) begin
      checks++; if (jtag_TDO_data !== exp_id[i] || jtag_TDO_driven !== 1'b1) begin errors++; $display("FAIL idcode_bit%0d got %b drv %b exp %b drv 1", i, jtag_TDO_data, jtag_TDO_driven, exp_id[i]); end
      jtag_clk(i == 31, 1'($urandom));
    end
    checks++; if (jtag_TDO_driven !== 1'b0 || tap_state !== 4'h1) begin errors++; $display("FAIL idcode_exit got drv %b st %h exp 0 1", jtag_TDO_driven, tap_state); end
    jtag_clk(1'b1, 1'b0); jtag_clk(1'b0, 1'b0);
    checks++; if (tap_state !== 4'(m_state) || dr_update_valid !== 1'b0) begin errors++; $display("FAIL idcode_rti got st %h v %b exp %h 0", tap_state, dr_update_valid, m_state); end
  endtask

  task automatic test_user_dr();
    logic [4:0]    icap;
    logic [63:0]   dout, din;
    logic [DW-1:0] cap;
    int            hi_cnt, first_hi;
    load_ir(UIR, icap);
    checks++; if (ir_value !== UIR || icap !== 5'b00001) begin errors++; $display("FAIL user_ir got %h cap %b exp %h 00001", ir_value, icap, UIR); end
    cap = {$urandom, $urandom};
    dr_capture_data = cap;
    set_ready(1'b1);
    din = 64'h1_2345_6789_A;
    shift_dr(din, DW, 1'b1, dout);
    jtag_TCK = 1'b0; model_fall(1'b1);
    hi_cnt = 0; first_hi = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (dr_update_valid) begin hi_cnt++; if (first_hi == 0) first_hi = i; end
    end
    wait_clks(1);
    checks++; if (hi_cnt != 1 || first_hi != 4) begin errors++; $display("FAIL user_valid_pulse got cnt %0d at %0d exp 1 at 4", hi_cnt, first_hi); end
    checks++; if (dr_update_data !== 41'h1_2345_6789_A) begin errors++; $display("FAIL user_data got %h exp %h", dr_update_data, 41'h1_2345_6789_A); end
    checks++; if (dout[DW-1:0] !== cap) begin errors++; $display("FAIL user_capture got %h exp %h", dout[DW-1:0], cap); end
    jtag_clk(1'b0, 1'b0);
    for (int unsigned n = 0; n < 3; n++) begin
      cap = {$urandom, $urandom};
      dr_capture_data = cap;
      din = {$urandom, $urandom};
      shift_dr(din, DW, 1'b0, dout);
      checks++; if (dout[DW-1:0] !== cap) begin errors++; $display("FAIL user_rand_capture got %h exp %h", dout[DW-1:0], cap); end
      checks++; if (dr_update_data !== din[DW-1:0] || dr_update_valid !== 1'b0) begin errors++; $display("FAIL user_rand_data got %h v %b exp %h 0", dr_update_data, dr_update_valid, din[DW-1:0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d1, d2, dout;
    set_ready(1'b0);
    d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    shift_dr(d1, DW, 1'b0, dout);
    checks++; if (dr_update_valid !== 1'b1 || dr_update_data !== d1[DW-1:0]) begin errors++; $display("FAIL b2b_first got v %b d %h exp 1 %h", dr_update_valid, dr_update_data, d1[DW-1:0]); end
    shift_dr(d2, DW, 1'b1, dout);
    jtag_TCK = 1'b0;
    wait_clks(2);
    dr_update_ready = 1'b1;
    wait_clks(1);
    dr_update_ready = 1'b0;
    model_fall(1'b1);
    wait_clks(3);
    checks++; if (dr_update_valid !== 1'b1 || dr_update_data !== d2[DW-1:0] || dr_overrun !== 1'b0) begin errors++; $display("FAIL b2b_same_cycle got v %b d %h o %b exp 1 %h 0", dr_update_valid, dr_update_data, dr_overrun, d2[DW-1:0]); end
    jtag_clk(1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    logic [63:0] d1, d2, dout;
    set_ready(1'b1);
    set_ready(1'b0);
    d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    shift_dr(d1, DW, 1'b0, dout);
    shift_dr(d2, DW, 1'b0, dout);
    checks++; if (dr_update_data !== d1[DW-1:0] || dr_update_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold got %h v %b exp %h 1", dr_update_data, dr_update_valid, d1[DW-1:0]); end
    checks++; if (dr_overrun !== 1'b1 || dr_overrun !== m_ovr) begin errors++; $display("FAIL ovr_flag got %b exp 1", dr_overrun); end
    repeat (5) jtag_clk(1'b1, 1'b0);
    checks++; if (tap_state !== 4'hF || dr_overrun !== 1'b0 || ir_value !== 5'h01) begin errors++; $display("FAIL ovr_tlr got st %h o %b ir %h exp F 0 01", tap_state, dr_overrun, ir_value); end
    checks++; if (dr_update_valid !== m_valid) begin errors++; $display("FAIL ovr_valid_kept got %b exp %b", dr_update_valid, m_valid); end
    set_ready(1'b1);
    checks++; if (dr_update_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", dr_update_valid); end
    set_ready(1'b0);
    jtag_clk(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    logic [4:0]  icap;
    logic [63:0] dout, din, exp_out;
    load_ir(5'h1F, icap);
    checks++; if (ir_value !== 5'h1F || icap !== 5'b00001) begin errors++; $display("FAIL byp_ir got %h cap %b exp 1F 00001", ir_value, icap); end
    din = 64'hA5;
    shift_dr(din, 8, 1'b0, dout);
    checks++; if (dout[7:0] !== 8'h4A) begin errors++; $display("FAIL byp_a5 got %h exp 4A", dout[7:0]); end
    din = 64'($urandom_range(0, 65535));
    exp_out = (din << 1) & 64'hFFFF;
    shift_dr(din, 16, 1'b0, dout);
    checks++; if (dout[15:0] !== exp_out[15:0] || dr_update_valid !== 1'b0) begin errors++; $display("FAIL byp_rand got %h v %b exp %h 0", dout[15:0], dr_update_valid, exp_out[15:0]); end
  endtask

  task automatic test_trst();
    int  first_tlr;
    logic drv_at4;
    jtag_clk(1'b1, 1'b0); jtag_clk(1'b0, 1'b0); jtag_clk(1'b0, 1'b0);
    checks++; if (tap_state !== 4'h2 || jtag_TDO_driven !== 1'b1) begin errors++; $display("FAIL trst_pre got st %h drv %b exp 2 1", tap_state, jtag_TDO_driven); end
    jtag_TRSTn = 1'b0;
    first_tlr = 0; drv_at4 = 1'bx;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (tap_state == 4'hF && first_tlr == 0) first_tlr = i;
      if (i == 4) drv_at4 = jtag_TDO_driven;
    end
    wait_clks(1);
    jtag_TRSTn = 1'b1;
    wait_clks(4);
    m_state = 15; m_drv = 1'b0; m_ir = 5'h01; m_ovr = 1'b0;
    checks++; if (first_tlr != 4) begin errors++; $display("FAIL trst_latency got %0d exp 4", first_tlr); end
    checks++; if (drv_at4 !== 1'b0) begin errors++; $display("FAIL trst_driven got %b exp 0", drv_at4); end
    checks++; if (ir_value !== 5'h01 || tap_state !== 4'hF) begin errors++; $display("FAIL trst_after got ir %h st %h exp 01 F", ir_value, tap_state); end
    jtag_clk(1'b0, 1'b0);
  endtask

  task automatic test_tck_high();
    jtag_rise(1'b1, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      jtag_TMS = ~jtag_TMS;
      wait_clks(4);
      checks++; if (tap_state !== 4'(m_state) || m_state != 7) begin errors++; $display("FAIL tck_high_%0d got %h exp 7", i, tap_state); end
    end
    jtag_fall();
    checks++; if (tap_state !== 4'h7) begin errors++; $display("FAIL tck_high_fall got %h exp 7", tap_state); end
    goto_rti();
  endtask

  task automatic test_reset_mid_shift();
    logic [4:0]    icap;
    logic [63:0]   dout, din;
    logic [DW-1:0] cap;
    load_ir(UIR, icap);
    dr_capture_data = {$urandom, $urandom};
    jtag_clk(1'b1, 1'b0); jtag_clk(1'b0, 1'b0); jtag_clk(1'b0, 1'b0);
    repeat (10) jtag_clk(1'b0, 1'($urandom));
    reset_n = 1'b0;
    #1;
    checks++; if (tap_state !== 4'hF || jtag_TDO_driven !== 1'b0 || ir_value !== 5'h01) begin errors++; $display("FAIL midrst_async got st %h drv %b ir %h exp F 0 01", tap_state, jtag_TDO_driven, ir_value); end
    wait_clks(2);
    reset_n = 1'b1;
    model_reset();
    wait_clks(4);
    jtag_clk(1'b0, 1'b0);
    load_ir(UIR, icap);
    cap = {$urandom, $urandom};
    dr_capture_data = cap;
    set_ready(1'b1);
    din = {$urandom, $urandom};
    shift_dr(din, DW, 1'b0, dout);
    checks++; if (dout[DW-1:0] !== cap || dr_update_data !== din[DW-1:0]) begin errors++; $display("FAIL midrst_fresh got cap %h d %h exp %h %h", dout[DW-1:0], dr_update_data, cap, din[DW-1:0]); end
  endtask

  task automatic test_random_walk();
    logic tms;
    dr_capture_data = {$urandom, $urandom};
    for (int unsigned i = 0; i < 120; i++) begin
      set_ready(1'($urandom));
      tms = ($urandom_range(0, 9) < 4);
      jtag_clk(tms, 1'($urandom));
      checks++; if (tap_state !== 4'(m_state)) begin errors++; $display("FAIL walk%0d_state got %h exp %h", i, tap_state, m_state); end
      checks++; if (jtag_TDO_driven !== m_drv || jtag_TDO_data !== m_tdo) begin errors++; $display("FAIL walk%0d_tdo got %b%b exp %b%b", i, jtag_TDO_driven, jtag_TDO_data, m_drv, m_tdo); end
      checks++; if (ir_value !== m_ir) begin errors++; $display("FAIL walk%0d_ir got %h exp %h", i, ir_value, m_ir); end
      checks++; if (dr_update_valid !== m_valid || dr_overrun !== m_ovr || dr_update_data !== m_data) begin errors++; $display("FAIL walk%0d_upd got v%b o%b d%h exp v%b o%b d%h", i, dr_update_valid, dr_overrun, dr_update_data, m_valid, m_ovr, m_data); end
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_user_dr();
    test_back_to_back();
    test_overrun();
    test_bypass();
    test_trst();
    test_tck_high();
    test_reset_mid_shift();
    test_random_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sync.md
JTAG_TAP_SYNC -- requirements
Module: jtag_tap_sync

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h00000001, the value captured by the IDCODE instruction; bit 0 is fixed to 1.
REQ-002 SHALL have parameter USER_IR, default 5'h11, the instruction selecting the user data register.
REQ-003 SHALL have parameter DATA_WIDTH, default 41, the user data register width.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 SHALL have port clock, input, 1, the sole clock; all logic rises on it.
REQ-006 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have ports jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, each input, 1, the JTAG pins, asynchronous to clock.
REQ-008 SHALL have port jtag_TDO_data, output, 1, the serial output.
REQ-009 SHALL have port jtag_TDO_driven, output, 1, high only while TDO is valid.
REQ-010 SHALL have port dr_capture_data, input, DATA_WIDTH, the value loaded at Capture-DR under USER_IR.
REQ-011 SHALL have port dr_update_valid, output, 1, high while an update is pending.
REQ-012 SHALL have port dr_update_ready, input, 1, the consumer accept signal.
REQ-013 SHALL have port dr_update_data, output, DATA_WIDTH, the shifted-in user data.
REQ-014 SHALL have port dr_overrun, output, 1, a sticky flag for an update lost while one was pending.
REQ-015 SHALL have port ir_value, output, 5, the current instruction.
REQ-016 SHALL have port tap_state, output, 4, the current TAP state.

Function
REQ-017 SHALL pass each JTAG input through a 2-flop synchronizer, then one history flop for TCK; a TCK rise or fall is the sync output differing from the history flop.
REQ-018 SHALL act on a TCK edge on the clock edge that detects it, so a pin change becomes visible on the outputs 3 clocks later.
REQ-019 SHALL implement the 16-state IEEE 1149.1 FSM advancing on TCK rise using synchronized TMS. Encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-020 SHALL make TLR reachable from any state by 5 consecutive TCK rises with TMS=1.
REQ-021 SHALL force TLR while synchronized TRSTn=0, regardless of TCK.
REQ-022 SHALL set ir_value to 5'h01 (IDCODE) on entering or remaining in TLR.
REQ-023 SHALL select the active DR by IR: 01 selects IDCODE (32 bits), USER_IR selects the user DR (DATA_WIDTH bits), and all other codes select BYPASS (1 bit, captures 0).
REQ-024 SHALL, on TCK rise in CapIR, load the IR shift register with 5'b00001.
REQ-025 SHALL, on TCK rise in CapDR, load the selected DR.
REQ-026 SHALL, on TCK rise in ShIR or ShDR, shift right with TDI entering the MSB of the selected register.
REQ-027 SHALL, on TCK fall, set jtag_TDO_data to the shift-register LSB and set jtag_TDO_driven to 1 if the state is ShIR/ShDR, else 0.
REQ-028 SHALL leave jtag_TDO_data holding its last value when not driven.
REQ-029 SHALL, on TCK fall in UpdIR, copy the IR shift register to ir_value.
REQ-030 SHALL, on TCK fall in UpdDR with ir_value==USER_IR, copy the user shift register to dr_update_data and set dr_update_valid.
REQ-031 SHALL, on an UpdDR update while dr_update_valid=1 and not accepted that cycle, keep the old data, assert dr_overrun, and drop the new data.
REQ-032 SHALL treat a clock with dr_update_valid and dr_update_ready both high as a transfer and clear valid next cycle; a same-cycle update and transfer loads the new data and keeps valid=1 with no overrun.
REQ-033 SHALL hold dr_update_data and valid stable while valid=1 and ready=0.
REQ-034 SHALL clear dr_overrun only by reset_n or by entering TLR.
REQ-035 SHALL drive tap_state from the FSM register.

Reset
REQ-036 SHALL, with reset_n=0, set tap_state=F, ir_value=01, jtag_TDO_data=0, jtag_TDO_driven=0, dr_update_valid=0, dr_update_data=0, dr_overrun=0, and synchronizers/history=0, with shift registers cleared.
REQ-037 SHALL leave the FSM in TLR after reset_n deasserts until a TCK rise with TMS=0.
REQ-038 SHALL apply reset immediately when reset_n is asserted mid-shift, discarding the partial shift.

Verification
REQ-039 SHALL cover: reset, then TMS 0,1,0,0 and shift 32 bits -> TDO returns 32'h00000001 LSB-first, driven=1 only during ShDR.
REQ-040 SHALL cover: IR load 5'h11, then DR shift 41'h1_2345_6789_A with ready=1 -> valid pulses 1 cycle after UpdDR fall, data=41'h1_2345_6789_A.
REQ-041 SHALL cover: two user DR updates with ready=0 -> first data is held and dr_overrun=1; TMS=1 for 5 TCKs -> overrun=0, ir_value=01.
REQ-042 SHALL cover: IR 5'h1F and shift 8 bits of TDI 0xA5 -> TDO shows 0 then TDI delayed by 1 TCK.
REQ-043 SHALL cover: TRSTn=0 pulse in ShDR -> tap_state=F 3 clocks later and driven=0.
REQ-044 SHALL cover: TCK held high with TMS toggling -> no state change.
